// File: rtl/parity_frame_checker_if.sv
// Bus bundle for parity_frame_checker: serial channel inputs, frame control and per-channel results.
// The master drives bits and clear; the slave (checker) returns parity, completion and error flags.
interface parity_frame_checker_if #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8
);
    localparam int CW = $clog2(FRAME_LEN);

    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             clear;
    logic [WIDTH-1:0] out_parity;
    logic             frame_done;
    logic [WIDTH-1:0] frame_err;
    logic [CW-1:0]    bit_count;

    modport master (
        output in, in_valid, clear,
        input  out_parity, frame_done, frame_err, bit_count
    );

    modport slave (
        input  in, in_valid, clear,
        output out_parity, frame_done, frame_err, bit_count
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Multi-channel serial frame parity checker: one capture stage, a running parity bit per channel,
// a shared bit counter and registered per-frame error flags with a one-cycle completion pulse.
module parity_frame_checker #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    parameter int ODD       = 0
) (
    input logic                  clock,
    input logic                  resetn,
    parity_frame_checker_if.slave bus
);
    localparam int               CW       = $clog2(FRAME_LEN);
    localparam logic [WIDTH-1:0] ODD_MASK = (ODD != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [CW-1:0]    LAST_IDX = CW'(FRAME_LEN - 1);

    logic [WIDTH-1:0] in_sync;
    logic             valid_sync;
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    bit_count;
    logic             frame_done;
    logic [WIDTH-1:0] frame_err;
    logic             last_bit;

    assign last_bit = valid_sync && (bit_count == LAST_IDX);

    // Clear is applied after capture, so the bit captured on the clear edge still lands in the next frame.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in_sync    <= '0;
            valid_sync <= 1'b0;
            s          <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
            frame_err  <= '0;
        end else begin
            in_sync    <= bus.in;
            valid_sync <= bus.in_valid;
            if (bus.clear) begin
                s          <= '0;
                bit_count  <= '0;
                frame_done <= 1'b0;
                frame_err  <= '0;
            end else if (last_bit) begin
                frame_err  <= s ^ in_sync ^ ODD_MASK;
                frame_done <= 1'b1;
                s          <= '0;
                bit_count  <= '0;
            end else begin
                frame_done <= 1'b0;
                if (valid_sync) begin
                    s         <= s ^ in_sync;
                    bit_count <= bit_count + 1'b1;
                end
            end
        end
    end

    assign bus.out_parity = s ^ (in_sync & {WIDTH{valid_sync}}) ^ ODD_MASK;
    assign bus.frame_done = frame_done;
    assign bus.frame_err  = frame_err;
    assign bus.bit_count  = bit_count;
endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of independent serial channels (legal range 1..32).
REQ-002 The block SHALL have parameter FRAME_LEN, default 8, giving bits per frame including the parity bit (legal range 2..256).
REQ-003 The block SHALL have parameter ODD, default 0: 0 selects even frame parity, 1 selects odd.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 in  input  WIDTH  one serial data bit per channel.
REQ-007 in_valid  input  1  qualifies in for the current cycle, common to all channels.
REQ-008 clear  input  1  synchronous frame abort, not synchronised.
REQ-009 out_parity  output  WIDTH  running (Mealy) parity per channel.
REQ-010 frame_done  output  1  registered one-cycle pulse at frame completion.
REQ-011 frame_err  output  WIDTH  registered per-channel parity-error flags of the last completed frame.
REQ-012 bit_count  output  clog2(FRAME_LEN)  number of valid bits accumulated in the current frame.

Function
REQ-013 One synchroniser register stage (enable tied high) SHALL capture in and in_valid on every edge, giving in_sync and valid_sync.
REQ-014 Each channel SHALL hold one state bit: s_next = s XOR in_sync when valid_sync=1, else s unchanged.
REQ-015 out_parity[i] SHALL equal s[i] XOR (in_sync[i] AND valid_sync) XOR ODD, combinationally; there is no register on this path.
REQ-016 The bit counter SHALL increment on each edge with valid_sync=1 and hold otherwise; gaps in in_valid SHALL NOT affect frame results.
REQ-017 The last bit is the edge where valid_sync=1 and bit_count=FRAME_LEN-1; on that edge the block SHALL set frame_err[i] = s[i] XOR in_sync[i] XOR ODD, set frame_done=1, and set every s and bit_count to 0.
REQ-018 frame_done SHALL be 1 for exactly one cycle per completed frame and 0 otherwise.
REQ-019 frame_err SHALL hold its value until the next completion, clear, or reset.
REQ-020 Latency: a bit applied before edge k is captured at k and accumulated at k+1. frame_done and frame_err for a frame whose last bit is captured at k SHALL be visible after edge k+1.
REQ-021 Back-to-back frames SHALL be accepted with no bubble; the bit after the last bit SHALL be bit 0 of the next frame.
REQ-022 clear=1 at an edge SHALL zero s, bit_count and frame_err, force frame_done to 0, and discard the in-flight valid_sync bit at that edge; clear SHALL take priority over frame completion.
REQ-023 clear SHALL NOT affect the synchroniser stage; a bit captured at the clear edge SHALL be accumulated normally on the following edge.
REQ-024 Channels SHALL be fully independent except for the shared in_valid, clear and counter.

Reset
REQ-025 resetn=0 SHALL immediately, without a clock, force the synchroniser, all s, bit_count, frame_done and frame_err to 0; out_parity then equals ODD on every bit.
REQ-026 After resetn rises, the first valid bit SHALL be counted as bit 0 of a new frame.
REQ-027 resetn=0 mid-frame SHALL discard the partial frame with no frame_done pulse.

Verification
REQ-028 Reset: WIDTH=4, FRAME_LEN=8, ODD=0; drive 3 valid bits, pull resetn low between edges -> bit_count=0, frame_err=0, frame_done=0, out_parity=4'b0000 with no clock edge.
REQ-029 Even frame: ch0 gets 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles, other channels 0 -> frame_done pulses once, 2 edges after the last bit is applied; frame_err=4'b0000.
REQ-030 Error plus gaps: ch1 gets 1,1,1,0,0,0,0,0 with 2 idle cycles after bits 2 and 5 -> bit_count holds during the gaps; frame_err=4'b0010 with a single frame_done pulse.
REQ-031 Clear: 5 valid bits, then clear=1 for one cycle, then 8 bits containing two 1s on ch2 -> no pulse for the aborted frame; the next frame gives frame_err=4'b0000.
REQ-032 Odd mode: ODD=1, back-to-back frames on ch3 with three 1s then four 1s -> two frame_done pulses exactly 8 cycles apart; frame_err[3]=0, then 1.
REQ-033 Mealy output: ODD=0, s[0]=1, in_sync[0]=1, valid_sync=1 -> out_parity[0]=0 before the edge; out_parity[0]=1 when valid_sync=0.
